// File: rtl/iddmm_pkg.sv
// iddmm_pkg: IDDMM task controller state encoding and default constants
package iddmm_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, WAIT, OUTPUT} state_t;
  localparam int DEF_K = 128;
  localparam int DEF_N = 32;
  localparam int DEF_TIMEOUT = 4096;
endpackage

// File: rtl/iddmm_task_ctrl_if.sv
// iddmm_task_ctrl_if: task handshake and result stream bundle
interface iddmm_task_ctrl_if import iddmm_pkg::*; #(
  parameter int K = DEF_K,
  parameter int ADDR_W = $clog2(DEF_N)
);
  logic task_valid, task_ready;
  logic [ADDR_W:0] task_nwords;
  logic res_valid, res_ready, res_last;
  logic [K-1:0] res_data;
  modport master (
    output task_valid, task_nwords, res_ready,
    input task_ready, res_valid, res_data, res_last
  );
  modport slave (
    input task_valid, task_nwords, res_ready,
    output task_ready, res_valid, res_data, res_last
  );
endinterface

// File: rtl/iddmm_idx_gen.sv
// iddmm_idx_gen: nested i/j scan counter with wrap and terminal flag
module iddmm_idx_gen #(
  parameter int N = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              park,
  input  logic [ADDR_W:0]   nw,
  output logic [ADDR_W-1:0] i,
  output logic [ADDR_W:0]   j,
  output logic              term
);
  logic w_wrap;
  assign w_wrap = j == nw;
  assign term = step && w_wrap && ({1'b0, i} == nw - 1'b1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i <= '0;
      j <= (ADDR_W+1)'(N);
    end else if (park) begin
      i <= '0;
      j <= (ADDR_W+1)'(N);
    end else if (!step || term) begin
      i <= '0;
      j <= '0;
    end else if (w_wrap) begin
      i <= i + 1'b1;
      j <= '0;
    end else
      j <= j + 1'b1;
endmodule

// File: rtl/iddmm_task_ctrl.sv
// iddmm_task_ctrl: IDDMM task sequencer (SCAN/WAIT/OUTPUT); IDDMM_TIMEOUT_EN adds a WAIT timeout
module iddmm_task_ctrl import iddmm_pkg::*; #(
  parameter int K = DEF_K,
  parameter int N = DEF_N,
  parameter int ADDR_W = $clog2(N),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  iddmm_task_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic [ADDR_W:0]   rd_addr_i,
  output logic [ADDR_W:0]   rd_addr_j,
  input  logic              cal_done,
  input  logic              cal_sign,
  output logic              fifo_rd_en,
  input  logic [K-1:0]      fifo_rd_data_a,
  input  logic [K-1:0]      fifo_rd_data_sub,
  output logic              busy,
  output logic              err_timeout
);
  localparam logic [ADDR_W:0] NW_MAX = (ADDR_W+1)'(N);
  state_t r_state;
  logic [ADDR_W:0] r_nw, r_beat, w_nw_in;
  logic [ADDR_W-1:0] w_i;
  logic [ADDR_W:0] w_j;
  logic r_busy, r_res_valid, w_term, w_hs, w_done, w_timeout, w_park;
  assign w_nw_in = bus.task_nwords == '0 ? (ADDR_W+1)'(1) :
                   bus.task_nwords > NW_MAX ? NW_MAX : bus.task_nwords;
  assign bus.task_ready = r_state == IDLE;
  assign bus.res_valid = r_res_valid;
  assign bus.res_last = r_res_valid && r_beat == r_nw - 1'b1;
  assign bus.res_data = cal_sign ? fifo_rd_data_sub : fifo_rd_data_a;
  assign w_hs = r_res_valid && bus.res_ready;
  assign w_done = w_hs && bus.res_last;
  assign fifo_rd_en = w_hs;
  assign busy = r_busy;
  assign rd_addr_i = {1'b0, w_i};
  assign rd_addr_j = w_j;
  assign w_park = (r_state == IDLE && !bus.task_valid) || w_done || w_timeout;
`ifdef IDDMM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;
  assign w_timeout = r_state == WAIT && !cal_done && r_wait == TW'(TIMEOUT - 1);
  assign err_timeout = w_timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wait <= '0;
    else r_wait <= r_state == WAIT ? r_wait + 1'b1 : '0;
`else
  assign w_timeout = 1'b0;
  assign err_timeout = TIMEOUT < 0;
`endif
  iddmm_idx_gen #(.N(N), .ADDR_W(ADDR_W)) u_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .step (r_state == SCAN),
    .park (w_park),
    .nw   (r_nw),
    .i    (w_i),
    .j    (w_j),
    .term (w_term)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i_cnt <= '0;
      j_cnt <= '0;
    end else begin
      i_cnt <= w_i;
      j_cnt <= w_j;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_nw <= (ADDR_W+1)'(1);
      r_beat <= '0;
      r_busy <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.task_valid) begin
          r_state <= SCAN;
          r_nw <= w_nw_in;
          r_busy <= 1'b1;
        end
        SCAN: if (w_term) r_state <= WAIT;
        WAIT: if (cal_done) begin
          r_state <= OUTPUT;
          r_res_valid <= 1'b1;
          r_beat <= '0;
        end else if (w_timeout) begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
        default: if (w_done) begin
          r_state <= IDLE;
          r_res_valid <= 1'b0;
          r_busy <= 1'b0;
          r_beat <= '0;
        end else if (w_hs) r_beat <= r_beat + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_iddmm_task_ctrl.sv
// tb_iddmm_task_ctrl: directed and randomized tasks checked against a loop-level reference model
module tb_iddmm_task_ctrl;
  localparam int K = 128, N = 32, AW = $clog2(N), TO = 16;
  logic clk = 0, rst_n = 1;
  logic [AW-1:0] i_cnt;
  logic [AW:0] j_cnt, rd_addr_i, rd_addr_j;
  logic cal_done = 0, cal_sign = 0, fifo_rd_en, busy, err_timeout;
  logic [K-1:0] fa, fs;
  logic [K-1:0] ra [0:N];
  logic [K-1:0] rs [0:N];
  int rp = 0;
  int n_vec = 0, n_bad = 0;
  iddmm_task_ctrl_if #(.K(K), .ADDR_W(AW)) bus();
  iddmm_task_ctrl #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .i_cnt(i_cnt), .j_cnt(j_cnt),
    .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j), .cal_done(cal_done), .cal_sign(cal_sign),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data_a(fa), .fifo_rd_data_sub(fs),
    .busy(busy), .err_timeout(err_timeout)
  );
  assign fa = ra[rp];
  assign fs = rs[rp];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chkd(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic pop;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop && rp < N) rp++;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, 32'(bus.task_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_addr_i"}, 32'(rd_addr_i), 0);
    chk({tag, "_addr_j"}, 32'(rd_addr_j), N);
  endtask
  task automatic run_task(input int nw_req, input bit sign, input int wt, input int mode);
    int nw, k, beat;
    int pi, pj;
    logic [K-1:0] prev;
    bit prev_rdy;
    nw = nw_req == 0 ? 1 : (nw_req > N ? N : nw_req);
    for (int x = 0; x <= N; x++) begin
      ra[x] = {$urandom, $urandom, $urandom, $urandom};
      rs[x] = {$urandom, $urandom, $urandom, $urandom};
    end
    rp = 0;
    cal_sign = sign;
    bus.task_valid = 1;
    bus.task_nwords = (AW+1)'(nw_req);
    #1;
    idle_chk("accept");
    cyc();
    bus.task_valid = 0;
    pi = 0;
    pj = N;
    for (int i = 0; i < nw; i++)
      for (int j = 0; j <= nw; j++) begin
        chk("scan_addr_i", 32'(rd_addr_i), i);
        chk("scan_addr_j", 32'(rd_addr_j), j);
        chk("scan_i_cnt", 32'(i_cnt), pi);
        chk("scan_j_cnt", 32'(j_cnt), pj);
        chk("scan_busy", 32'(busy), 1);
        pi = i;
        pj = j;
        cyc();
      end
    chk("wait_i_cnt", 32'(i_cnt), nw - 1);
    chk("wait_j_cnt", 32'(j_cnt), nw);
    for (int c = 0; c <= wt; c++) begin
      cal_done = c == wt;
      #1;
      chk("wait_valid", 32'(bus.res_valid), 0);
      chk("wait_addr", 32'({rd_addr_i, rd_addr_j}), 0);
      chk("wait_err", 32'(err_timeout), 0);
      chk("wait_busy", 32'(busy), 1);
      cyc();
    end
    cal_done = 0;
    beat = 0;
    k = 0;
    prev = '0;
    prev_rdy = 1;
    while (beat < nw && k < 8 * nw + 8) begin
      bus.res_ready = (mode == 0) || (mode == 1 && (k % 4 == 0 || k % 4 == 3)) ||
                      (mode == 2 && $urandom_range(0, 1) == 1);
      #1;
      chk("out_valid", 32'(bus.res_valid), 1);
      chkd("out_data", bus.res_data, sign ? rs[beat] : ra[beat]);
      if (!prev_rdy) chkd("out_stall_hold", bus.res_data, prev);
      chk("out_last", 32'(bus.res_last), beat == nw - 1 ? 1 : 0);
      chk("out_rd_en", 32'(fifo_rd_en), bus.res_ready ? 1 : 0);
      chk("out_busy", 32'(busy), 1);
      prev = bus.res_data;
      prev_rdy = bus.res_ready;
      if (bus.res_ready) beat++;
      k++;
      cyc();
    end
    chk("out_beats", beat, nw);
    bus.res_ready = 0;
  endtask
  initial begin
    bus.task_valid = 0;
    bus.task_nwords = '0;
    bus.res_ready = 0;
    #2 rst_n = 0;
    #1;
    idle_chk("reset");
    chk("reset_i_cnt", 32'(i_cnt), 0);
    chk("reset_j_cnt", 32'(j_cnt), 0);
    chk("reset_err", 32'(err_timeout), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc();
    run_task(4, 1, 3, 0);
    run_task(4, 0, 5, 1);
    run_task(32, 0, 10, 0);
    run_task(0, 1, 0, 2);
    run_task(N + 5, 1, 2, 2);
    for (int t = 0; t < 6; t++)
      run_task(int'($urandom_range(1, 9)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 12)), 2);
    #1;
    idle_chk("final");
    cyc();
    bus.task_valid = 1;
    bus.task_nwords = 8;
    cyc();
    bus.task_valid = 0;
    repeat (2 * 9 + 5) cyc();
    chk("abort_pre_i", 32'(rd_addr_i), 2);
    chk("abort_pre_j", 32'(rd_addr_j), 5);
    rst_n = 0;
    #1;
    idle_chk("abort");
    chk("abort_i_cnt", 32'(i_cnt), 0);
    chk("abort_j_cnt", 32'(j_cnt), 0);
    cyc();
    rst_n = 1;
    cyc();
    idle_chk("abort_after");
`ifdef IDDMM_TIMEOUT_EN
    bus.task_valid = 1;
    bus.task_nwords = 2;
    cyc();
    bus.task_valid = 0;
    repeat (6) cyc();
    for (int c = 1; c <= TO; c++) begin
      chk("to_err", 32'(err_timeout), c == TO ? 1 : 0);
      chk("to_busy", 32'(busy), 1);
      cyc();
    end
    idle_chk("to_idle");
    chk("to_err_clear", 32'(err_timeout), 0);
`endif
    run_task(3, 0, 1, 1);
    #1;
    idle_chk("end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iddmm_task_ctrl.md
IDDMM_TASK_CTRL -- requirements
Module: iddmm_task_ctrl

Interface
REQ-001 SHALL have parameter K, default 128, operand word width in bits.
REQ-002 SHALL have parameter N, default 32, maximum words per operand.
REQ-003 SHALL have parameter ADDR_W, default $clog2(N), word-index width.
REQ-004 SHALL have parameter TIMEOUT, default 4096, maximum WAIT cycles; used only under IDDMM_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports task_valid (input, 1) and task_ready (output, 1): task handshake.
REQ-008 SHALL have port task_nwords, input, ADDR_W+1: word count for this task, legal range 1..N.
REQ-009 SHALL have ports i_cnt (output, ADDR_W) and j_cnt (output, ADDR_W+1): registered loop indices to the datapath.
REQ-010 SHALL have ports rd_addr_i (output, ADDR_W+1) and rd_addr_j (output, ADDR_W+1): operand RAM read addresses.
REQ-011 SHALL have ports cal_done (input, 1) and cal_sign (input, 1): datapath completion and final-subtract select.
REQ-012 SHALL have ports fifo_rd_en (output, 1), fifo_rd_data_a (input, K) and fifo_rd_data_sub (input, K): show-ahead result FIFOs.
REQ-013 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, K) and res_last (output, 1): result stream.
REQ-014 SHALL have ports busy (output, 1) and err_timeout (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, WAIT, OUTPUT.
REQ-016 SHALL assert task_ready only in IDLE; a task is accepted on task_valid&task_ready, latching nw=task_nwords.
REQ-017 SHALL clamp a latched nw of 0 to 1 and a latched nw above N to N.
REQ-018 SHALL, in SCAN, step (i,j) per cycle with j 0..nw, then j wraps to 0 and i increments; start (0,0).
REQ-019 SHALL leave SCAN for WAIT the cycle after (i,j)=(nw-1,nw) is presented; SCAN lasts nw*(nw+1) cycles.
REQ-020 SHALL drive rd_addr_i/rd_addr_j combinationally from the internal counters; i_cnt/j_cnt equal them delayed one cycle.
REQ-021 SHALL hold internal counters at i=0, j=N in IDLE and at 0,0 in WAIT and OUTPUT.
REQ-022 SHALL move WAIT->OUTPUT on cal_done; a cal_done outside WAIT is ignored.
REQ-023 SHALL, in OUTPUT, assert res_valid and set res_data = cal_sign ? fifo_rd_data_sub : fifo_rd_data_a.
REQ-024 SHALL drive fifo_rd_en = res_valid & res_ready combinationally; hold res_data while res_ready is low.
REQ-025 SHALL count output beats 0..nw-1; res_last high on beat nw-1; OUTPUT->IDLE on the last handshake.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL permit a new task acceptance on the first IDLE cycle after the last beat, without a dead cycle.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-task, enter IDLE and abandon the task.
REQ-029 SHALL reset internal counters to i=0, j=N; reset i_cnt, j_cnt, output count, busy, res_valid and err_timeout to 0.
REQ-030 SHALL reset task_ready to 1 after reset release, as it is decoded from IDLE.

Configuration
REQ-031 SHALL, with IDDMM_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT with no cal_done, pulse err_timeout 1 cycle and enter IDLE.
REQ-032 SHALL, without IDDMM_TIMEOUT_EN, wait indefinitely and tie err_timeout to 0.

Structure
REQ-033 SHALL place the FSM state enum and the default constants in package iddmm_pkg.
REQ-034 SHALL use one sub-module, iddmm_idx_gen, for the nested i/j counter with wrap and terminal flag.

Verification
REQ-035 SHALL cover N=32, nw=32, cal_done 10 cycles after WAIT, res_ready=1 -> SCAN 1056 cycles, 32 beats, res_last on beat 31.
REQ-036 SHALL cover nw=4, cal_sign=1 -> res_data equals fifo_rd_data_sub; 20 SCAN cycles; final address pair (3,4).
REQ-037 SHALL cover res_ready toggling 1,0,0,1 -> fifo_rd_en only on handshake cycles; res_data stable while stalled.
REQ-038 SHALL cover rst_n low during SCAN at (2,5) -> next cycle IDLE, busy=0, task_ready=1, counters at i=0, j=N.
REQ-039 SHALL cover, with IDDMM_TIMEOUT_EN and TIMEOUT=16, cal_done withheld -> err_timeout pulse on WAIT cycle 16, then IDLE.
REQ-040 SHALL cover task_nwords=0 and task_nwords=N+5 -> treated as nw=1 (2 SCAN cycles) and nw=N respectively.
